// File: rtl/fp_accumulator_if.sv
// Operand stream and accumulator status bundle for fp_accumulator.
// The master drives operands and clear; the slave reports sum and flags.
interface fp_accumulator_if #(
  parameter int COUNT_W = 8
);
  logic               clear;
  logic               in_valid;
  logic [31:0]        in_data;
  logic               in_ready;
  logic [31:0]        sum;
  logic               sum_valid;
  logic [COUNT_W-1:0] count;
  logic               err;
  logic               ovf;

  modport master (
    output clear,
    output in_valid,
    output in_data,
    input  in_ready,
    input  sum,
    input  sum_valid,
    input  count,
    input  err,
    input  ovf
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  in_data,
    output in_ready,
    output sum,
    output sum_valid,
    output count,
    output err,
    output ovf
  );
endinterface

// File: rtl/fp_accumulator.sv
// Multi-cycle binary32 accumulator for non-negative operands.
// One shared align/add/normalise path, truncating, stepped by a 4-state FSM.
module fp_accumulator #(
  parameter int COUNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM
  } state_t;

  localparam logic [31:0] INF = 32'h7F80_0000;

  state_t r_state;
  state_t w_next;

  logic [30:0]        r_opnd;
  logic [31:0]        r_sum;
  logic [COUNT_W-1:0] r_count;
  logic               r_sum_valid;
  logic               r_err;
  logic               r_ovf;
  logic [7:0]         r_exp;
  logic [23:0]        r_mbig;
  logic [23:0]        r_msmall;
  logic [24:0]        r_msum;

  logic        w_ready;
  logic        w_xfer;
  logic        w_illegal;
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [23:0] w_ma;
  logic [23:0] w_mb;
  logic        w_a_big;
  logic [7:0]  w_diff;
  logic [23:0] w_small;
  logic [23:0] w_shift;
  logic [8:0]  w_exp9;
  logic [22:0] w_frac;
  logic        w_of;

  assign w_ready   = (r_state == S_IDLE) && !bus.clear;
  assign w_xfer    = bus.in_valid && w_ready;
  assign w_illegal = bus.in_data[31] ||
                     (bus.in_data[30:23] == 8'hFF);

  assign bus.in_ready  = w_ready;
  assign bus.sum       = r_sum;
  assign bus.sum_valid = r_sum_valid;
  assign bus.count     = r_count;
  assign bus.err       = r_err;
  assign bus.ovf       = r_ovf;

  // Exponent 0 carries no hidden bit, so zero and flushed operands align as 0.
  assign w_ea = r_sum[30:23];
  assign w_eb = r_opnd[30:23];
  assign w_ma = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_sum[22:0]};
  assign w_mb = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_opnd[22:0]};

  assign w_a_big = (w_ea >= w_eb);
  assign w_diff  = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
  assign w_small = w_a_big ? w_mb : w_ma;
  assign w_shift = (w_diff >= 8'd24) ? 24'd0 : (w_small >> w_diff);

  assign w_exp9 = {1'b0, r_exp} + {8'd0, r_msum[24]};
  assign w_frac = r_msum[24] ? r_msum[23:1] : r_msum[22:0];
  assign w_of   = r_ovf || (w_exp9 >= 9'd255);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_xfer && !w_illegal) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd      <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_sum_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_exp       <= '0;
      r_mbig      <= '0;
      r_msmall    <= '0;
      r_msum      <= '0;
    end else if (bus.clear) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_sum_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_xfer && w_illegal) begin
            r_err <= 1'b1;
          end else if (w_xfer) begin
            r_opnd <= (bus.in_data[30:23] == 8'd0) ?
                      31'd0 : bus.in_data[30:0];
          end
        end
        S_ALIGN: begin
          r_exp    <= w_a_big ? w_ea : w_eb;
          r_mbig   <= w_a_big ? w_ma : w_mb;
          r_msmall <= w_shift;
        end
        S_ADD: begin
          r_msum <= {1'b0, r_mbig} + {1'b0, r_msmall};
        end
        S_NORM: begin
          r_sum_valid <= 1'b1;
          if (r_count != '1) r_count <= r_count + 1'b1;
          // Saturate to +inf and stay there until clear.
          if (w_of) begin
            r_sum <= INF;
            r_ovf <= 1'b1;
          end else begin
            r_sum <= {1'b0, w_exp9[7:0], w_frac};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: exact-sum reference model truncated
// to 24 significant bits, directed scenarios plus randomized operands.
module tb_fp_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_accumulator_if #(.COUNT_W(8)) ifc();

  fp_accumulator #(.COUNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  typedef struct {
    logic [31:0] sum;
    int          cnt;
    bit          ovf;
    int          t;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_first = 0;
  int t_last = 0;

  logic [31:0] m_sum = 32'h0;
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  bit          m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Exact sum of the two values, truncated toward zero to 24 bits.
  function automatic logic [31:0] fadd(logic [31:0] s, logic [31:0] x);
    longint unsigned ms, mx, hi, lo, acc;
    int es, ex, e, d;
    if (x[30:23] == 8'd0) return s;
    if (s == 32'h0) return x;
    es = int'(s[30:23]);
    ex = int'(x[30:23]);
    ms = {40'd1, s[22:0]};
    mx = {40'd1, x[22:0]};
    if (es >= ex) begin
      hi = ms; lo = mx; d = es - ex; e = ex;
    end else begin
      hi = mx; lo = ms; d = ex - es; e = es;
    end
    if (d >= 24) return (es >= ex) ? s : x;
    acc = (hi << d) + lo;
    while (acc >= 64'h100_0000) begin
      acc = acc >> 1;
      e++;
    end
    if (e >= 255) return 32'h7F80_0000;
    return {1'b0, 8'(e), acc[22:0]};
  endfunction

  function automatic logic [31:0] i2f(int a);
    int msb;
    logic [31:0] v;
    msb = 0;
    for (int i = 0; i < 31; i++) if (a[i]) msb = i;
    v = 32'(a) << (23 - msb);
    return {1'b0, 8'(127 + msb), v[22:0]};
  endfunction

  task automatic model_reset();
    sbq.delete();
    m_sum = 32'h0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_xfer(input logic [31:0] x);
    exp_t e;
    if (x[31] || x[30:23] == 8'hFF) begin
      m_err = 1'b1;
      return;
    end
    if (!m_ovf) begin
      m_sum = fadd(m_sum, x);
      if (m_sum == 32'h7F80_0000) m_ovf = 1'b1;
    end
    if (m_cnt < 255) m_cnt++;
    e.sum = m_sum;
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    e.t   = cyc;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [31:0] x);
    int n;
    n = 0;
    ifc.in_data  = x;
    ifc.in_valid = 1'b1;
    while (!ifc.in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready=0 want 1");
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    model_xfer(x);
    t_last = cyc;
    chk("err_after_xfer", 64'(ifc.err), 64'(m_err));
  endtask

  task automatic drain();
    int n;
    n = 0;
    ifc.in_valid = 1'b0;
    while ((sbq.size() != 0 || !ifc.in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  task automatic do_clear(input bit with_valid);
    @(negedge clk);
    ifc.in_data  = 32'h3F80_0000;
    ifc.in_valid = with_valid;
    ifc.clear    = 1'b1;
    @(posedge clk);
    #1;
    ifc.clear    = 1'b0;
    ifc.in_valid = 1'b0;
    model_reset();
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_sum"},   64'(ifc.sum),   64'(m_sum));
    chk({nm, "_count"}, 64'(ifc.count), 64'(m_cnt));
    chk({nm, "_ovf"},   64'(ifc.ovf),   64'(m_ovf));
    chk({nm, "_err"},   64'(ifc.err),   64'(m_err));
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.sum_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_sum_valid: sum=%h count=%0d",
                 ifc.sum, ifc.count);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_sum",     64'(ifc.sum),   64'(e.sum));
        chk("sb_count",   64'(ifc.count), 64'(e.cnt));
        chk("sb_ovf",     64'(ifc.ovf),   64'(e.ovf));
        chk("sb_latency", 64'(cyc - e.t), 64'd3);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    int r;
    ifc.clear    = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_sum",       64'(ifc.sum),       64'd0);
    chk("rst_count",     64'(ifc.count),     64'd0);
    chk("rst_sum_valid", 64'(ifc.sum_valid), 64'd0);
    chk("rst_err",       64'(ifc.err),       64'd0);
    chk("rst_ovf",       64'(ifc.ovf),       64'd0);
    chk("rst_in_ready",  64'(ifc.in_ready),  64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    send(32'h3F80_0000);
    send(32'h4000_0000);
    drain();
    chk("t1_sum",   64'(ifc.sum),   64'h4040_0000);
    chk("t1_count", 64'(ifc.count), 64'd2);

    do_clear(1'b0);
    for (int a = 1; a <= 15; a++) begin
      send(i2f(a));
      if (a == 1) t_first = t_last;
    end
    drain();
    chk("t2_sum",   64'(ifc.sum),   64'h42F0_0000);
    chk("t2_count", 64'(ifc.count), 64'd15);
    chk("t2_span",  64'(t_last - t_first), 64'd56);

    do_clear(1'b0);
    send(32'h4170_0000);
    send(32'h4170_0000);
    drain();
    chk("t3_sum", 64'(ifc.sum), 64'h41F0_0000);
    send(32'h0000_0000);
    drain();
    chk("t3_zero_sum",   64'(ifc.sum),   64'h41F0_0000);
    chk("t3_zero_count", 64'(ifc.count), 64'd3);

    do_clear(1'b0);
    send(32'h4B80_0000);
    send(32'h3F80_0000);
    drain();
    chk("t4_trunc_sum", 64'(ifc.sum), 64'h4B80_0000);
    send(32'h7F7F_FFFF);
    send(32'h7F7F_FFFF);
    drain();
    chk("t4_inf_sum", 64'(ifc.sum), 64'h7F80_0000);
    chk("t4_ovf",     64'(ifc.ovf), 64'd1);
    send(32'h3F80_0000);
    drain();
    check_state("t4_after_ovf");

    send(32'hBF80_0000);
    send(32'h7FC0_0000);
    drain();
    chk("t5_err",   64'(ifc.err),   64'd1);
    chk("t5_count", 64'(ifc.count), 64'd5);
    chk("t5_sum",   64'(ifc.sum),   64'h7F80_0000);
    do_clear(1'b1);
    repeat (5) @(negedge clk);
    chk("t5_clr_err",   64'(ifc.err),   64'd0);
    chk("t5_clr_sum",   64'(ifc.sum),   64'd0);
    chk("t5_clr_count", 64'(ifc.count), 64'd0);
    chk("t5_clr_ovf",   64'(ifc.ovf),   64'd0);

    send(32'h3F80_0000);
    drain();
    send(32'h4000_0000);
    do_clear(1'b0);
    repeat (5) @(negedge clk);
    chk("t6_clr_sum",   64'(ifc.sum),      64'd0);
    chk("t6_clr_count", 64'(ifc.count),    64'd0);
    chk("t6_clr_ready", 64'(ifc.in_ready), 64'd1);

    send(32'h3F80_0000);
    drain();
    send(32'h4000_0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_sum_async", 64'(ifc.sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_rst_sum",   64'(ifc.sum),      64'd0);
    chk("t6_rst_count", 64'(ifc.count),    64'd0);
    chk("t6_rst_ready", 64'(ifc.in_ready), 64'd1);

    do_clear(1'b0);
    for (int i = 0; i < 360; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      x = 32'h0;
      else if (r == 1) x = {9'd0, 23'($urandom)};
      else if (r == 2) x = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
      else if (r == 3) x = {1'b0, 8'hFF, 23'($urandom)};
      else             x = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
      send(x);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    check_state("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
